// File: rtl/ast_dmx_routed_if.sv
// Avalon-ST bus bundle for ast_dmx_routed: one sink port plus TX_DIR source ports.
// The slave modport is the demultiplexer; the master modport is its upstream/downstream environment.
interface ast_dmx_routed_if #(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned CHANNEL_WIDTH = 8,
    parameter int unsigned EMPTY_WIDTH   = $clog2(DATA_WIDTH / 8),
    parameter int unsigned TX_DIR        = 4
);
    logic [DATA_WIDTH-1:0]                 ast_data_i;
    logic                                  ast_startofpacket_i;
    logic                                  ast_endofpacket_i;
    logic                                  ast_valid_i;
    logic [EMPTY_WIDTH-1:0]                ast_empty_i;
    logic [CHANNEL_WIDTH-1:0]              ast_channel_i;
    logic                                  ast_ready_o;

    logic [TX_DIR-1:0][DATA_WIDTH-1:0]     ast_data_o;
    logic [TX_DIR-1:0]                     ast_startofpacket_o;
    logic [TX_DIR-1:0]                     ast_endofpacket_o;
    logic [TX_DIR-1:0]                     ast_valid_o;
    logic [TX_DIR-1:0][EMPTY_WIDTH-1:0]    ast_empty_o;
    logic [TX_DIR-1:0][CHANNEL_WIDTH-1:0]  ast_channel_o;
    logic [TX_DIR-1:0]                     ast_ready_i;

    modport master (
        output ast_data_i, ast_startofpacket_i, ast_endofpacket_i, ast_valid_i,
               ast_empty_i, ast_channel_i, ast_ready_i,
        input  ast_ready_o, ast_data_o, ast_startofpacket_o, ast_endofpacket_o,
               ast_valid_o, ast_empty_o, ast_channel_o
    );

    modport slave (
        input  ast_data_i, ast_startofpacket_i, ast_endofpacket_i, ast_valid_i,
               ast_empty_i, ast_channel_i, ast_ready_i,
        output ast_ready_o, ast_data_o, ast_startofpacket_o, ast_endofpacket_o,
               ast_valid_o, ast_empty_o, ast_channel_o
    );
endinterface

// File: rtl/ast_dmx_routed.sv
// Avalon-ST 1-to-TX_DIR packet demux with per-direction output register, packet dropping and drop counter.
// Optional per-direction completed-packet counters: define AST_DMX_ROUTED_PKT_CNT_EN.
module ast_dmx_routed #(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned CHANNEL_WIDTH = 8,
    parameter int unsigned EMPTY_WIDTH   = $clog2(DATA_WIDTH / 8),
    parameter int unsigned TX_DIR        = 4,
    parameter int unsigned DIR_SEL_WIDTH = (TX_DIR == 1) ? 1 : $clog2(TX_DIR),
    parameter int unsigned DIR_MODE      = 0,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                     clk_i,
    input  logic                     srst_i,
    input  logic [DIR_SEL_WIDTH-1:0] dir_i,
    ast_dmx_routed_if.slave          ast,
    output logic [CNT_WIDTH-1:0]     drop_cnt_o
`ifdef AST_DMX_ROUTED_PKT_CNT_EN
    ,
    output logic [TX_DIR-1:0][CNT_WIDTH-1:0] pkt_cnt_o
`endif
);

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    state_t                               state_q, state_d;
    logic [DIR_SEL_WIDTH-1:0]             dir_q, dir_d;
    logic [DIR_SEL_WIDTH-1:0]             sel_in, wr_dir;
    logic                                 sel_ok, ready, wr_en, drop_inc;
    logic [TX_DIR-1:0]                    slot_free;

    logic [TX_DIR-1:0][DATA_WIDTH-1:0]    data_q;
    logic [TX_DIR-1:0]                    sop_q, eop_q, valid_q;
    logic [TX_DIR-1:0][EMPTY_WIDTH-1:0]   empty_q;
    logic [TX_DIR-1:0][CHANNEL_WIDTH-1:0] channel_q;
    logic [CNT_WIDTH-1:0]                 drop_q;

    assign sel_in    = (DIR_MODE == 1) ? ast.ast_channel_i[DIR_SEL_WIDTH-1:0] : dir_i;
    assign sel_ok    = 32'(sel_in) < TX_DIR;
    assign slot_free = ~valid_q | ast.ast_ready_i;

    // Next state, sink ready and output-slice write strobe
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        ready    = 1'b1;
        wr_en    = 1'b0;
        wr_dir   = dir_q;
        drop_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (ast.ast_valid_i && ast.ast_startofpacket_i) begin
                    if (sel_ok) begin
                        ready  = slot_free[sel_in];
                        wr_dir = sel_in;
                        if (ready) begin
                            wr_en = 1'b1;
                            dir_d = sel_in;
                            if (!ast.ast_endofpacket_i) state_d = FWD;
                        end
                    end else begin
                        drop_inc = 1'b1;
                        if (!ast.ast_endofpacket_i) state_d = DROP;
                    end
                end
            end
            FWD: begin
                ready = slot_free[dir_q];
                if (ast.ast_valid_i && ready) begin
                    wr_en = 1'b1;
                    if (ast.ast_endofpacket_i) state_d = IDLE;
                end
            end
            DROP: begin
                if (ast.ast_valid_i && ast.ast_endofpacket_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (srst_i) ready = 1'b0;
    end

    assign ast.ast_ready_o = ready;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q   <= IDLE;
            dir_q     <= '0;
            drop_q    <= '0;
            data_q    <= '0;
            sop_q     <= '0;
            eop_q     <= '0;
            valid_q   <= '0;
            empty_q   <= '0;
            channel_q <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            if (drop_inc && (drop_q != '1)) drop_q <= drop_q + CNT_WIDTH'(1);
            // A write always wins; otherwise a downstream handshake empties the slot
            for (int d = 0; d < TX_DIR; d++) begin
                if (wr_en && (wr_dir == DIR_SEL_WIDTH'(d))) begin
                    data_q[d]    <= ast.ast_data_i;
                    sop_q[d]     <= ast.ast_startofpacket_i;
                    eop_q[d]     <= ast.ast_endofpacket_i;
                    empty_q[d]   <= ast.ast_empty_i;
                    channel_q[d] <= ast.ast_channel_i;
                    valid_q[d]   <= 1'b1;
                end else if (ast.ast_ready_i[d]) begin
                    valid_q[d]   <= 1'b0;
                end
            end
        end
    end

    assign ast.ast_data_o          = data_q;
    assign ast.ast_startofpacket_o = sop_q;
    assign ast.ast_endofpacket_o   = eop_q;
    assign ast.ast_valid_o         = valid_q;
    assign ast.ast_empty_o         = empty_q;
    assign ast.ast_channel_o       = channel_q;
    assign drop_cnt_o              = drop_q;

`ifdef AST_DMX_ROUTED_PKT_CNT_EN
    logic [TX_DIR-1:0][CNT_WIDTH-1:0] pkt_q;

    // Completed packet = output handshake carrying eop
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            pkt_q <= '0;
        end else begin
            for (int d = 0; d < TX_DIR; d++) begin
                if (valid_q[d] && ast.ast_ready_i[d] && eop_q[d] && (pkt_q[d] != '1))
                    pkt_q[d] <= pkt_q[d] + CNT_WIDTH'(1);
            end
        end
    end

    assign pkt_cnt_o = pkt_q;
`endif

endmodule

// File: tb/tb_ast_dmx_routed.sv
// Self-checking bench for ast_dmx_routed (TX_DIR=3, so direction 3 is a drop target).
// A queue-per-direction reference model checks every cycle; packet tables and directed sequences add end checks.
module tb_ast_dmx_routed;
    localparam int unsigned DW   = 64;
    localparam int unsigned CW   = 8;
    localparam int unsigned EW   = 3;
    localparam int unsigned TX   = 3;
    localparam int unsigned SW   = 2;
    localparam int unsigned CNTW = 16;

    logic          clk = 1'b0;
    logic          srst;
    logic [SW-1:0] dir;
    logic [CNTW-1:0] drop_cnt;
`ifdef AST_DMX_ROUTED_PKT_CNT_EN
    logic [TX-1:0][CNTW-1:0] pkt_cnt;
`endif

    always #5 clk = ~clk;

    ast_dmx_routed_if #(.DATA_WIDTH(DW), .CHANNEL_WIDTH(CW), .EMPTY_WIDTH(EW), .TX_DIR(TX)) bus ();

    ast_dmx_routed #(
        .DATA_WIDTH(DW), .CHANNEL_WIDTH(CW), .EMPTY_WIDTH(EW), .TX_DIR(TX),
        .DIR_SEL_WIDTH(SW), .DIR_MODE(0), .CNT_WIDTH(CNTW)
    ) dut (
        .clk_i      (clk),
        .srst_i     (srst),
        .dir_i      (dir),
        .ast        (bus),
        .drop_cnt_o (drop_cnt)
`ifdef AST_DMX_ROUTED_PKT_CNT_EN
        ,
        .pkt_cnt_o  (pkt_cnt)
`endif
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
        logic [CW-1:0] channel;
    } beat_t;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: in-flight beats per direction, packet state, drop count
    beat_t mq [TX][$];
    int    m_state = 0;   // 0 idle, 1 forwarding, 2 dropping
    int    m_dir   = 0;
    int    m_drop  = 0;
    int    rcv_beats [TX];

    logic        rnd_ready = 1'b0;
    logic [TX-1:0] ready_set = '1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream ready driver (sole writer of ast_ready_i)
    initial begin
        bus.ast_ready_i = '1;
        forever begin
            @(posedge clk);
            #2;
            bus.ast_ready_i = rnd_ready ? TX'($urandom) : ready_set;
        end
    end

    // Model check and update, sampled mid-cycle while inputs are stable
    always @(negedge clk) begin : model
        int    sel;
        logic  exp_rdy, acc;
        beat_t b;
        if (srst) begin
            check("ready_in_reset", 64'(bus.ast_ready_o), 64'(0));
            for (int d = 0; d < TX; d++) mq[d].delete();
            m_state = 0;
            m_drop  = 0;
        end else begin
            for (int d = 0; d < TX; d++) begin
                check($sformatf("valid_o[%0d]", d), 64'(bus.ast_valid_o[d]), 64'(mq[d].size() != 0));
                if (bus.ast_valid_o[d] && mq[d].size() != 0) begin
                    b = mq[d][0];
                    check($sformatf("data_o[%0d]", d), bus.ast_data_o[d], b.data);
                    check($sformatf("sop_eop_o[%0d]", d),
                          64'({bus.ast_startofpacket_o[d], bus.ast_endofpacket_o[d]}), 64'({b.sop, b.eop}));
                    check($sformatf("empty_chan_o[%0d]", d),
                          64'({bus.ast_empty_o[d], bus.ast_channel_o[d]}), 64'({b.empty, b.channel}));
                end
            end
            check("drop_cnt", 64'(drop_cnt), 64'(m_drop));

            sel = (m_state == 1) ? m_dir : int'(dir);
            if (m_state == 1 || (m_state == 0 && bus.ast_valid_i && bus.ast_startofpacket_i && sel < int'(TX)))
                exp_rdy = (mq[sel].size() == 0) || bus.ast_ready_i[sel];
            else
                exp_rdy = 1'b1;
            check("ready_o", 64'(bus.ast_ready_o), 64'(exp_rdy));

            for (int d = 0; d < TX; d++) begin
                if (bus.ast_valid_o[d] && bus.ast_ready_i[d] && mq[d].size() != 0) begin
                    rcv_beats[d]++;
                    void'(mq[d].pop_front());
                end
            end

            acc = bus.ast_valid_i && bus.ast_ready_o;
            b   = '{bus.ast_data_i, bus.ast_startofpacket_i, bus.ast_endofpacket_i,
                    bus.ast_empty_i, bus.ast_channel_i};
            if (acc) begin
                if (m_state == 0) begin
                    if (b.sop) begin
                        if (sel < int'(TX)) begin
                            mq[sel].push_back(b);
                            m_dir   = sel;
                            m_state = b.eop ? 0 : 1;
                        end else begin
                            if (m_drop < (1 << CNTW) - 1) m_drop++;
                            m_state = b.eop ? 0 : 2;
                        end
                    end
                end else if (m_state == 1) begin
                    mq[m_dir].push_back(b);
                    if (b.eop) m_state = 0;
                end else if (b.eop) begin
                    m_state = 0;
                end
            end
        end
    end

    task automatic send_beat(input logic [DW-1:0] d, input logic s, input logic e,
                             input logic [EW-1:0] emp, input logic [CW-1:0] ch);
        int   n = 0;
        logic acc;
        bus.ast_data_i          = d;
        bus.ast_startofpacket_i = s;
        bus.ast_endofpacket_i   = e;
        bus.ast_empty_i         = emp;
        bus.ast_channel_i       = ch;
        bus.ast_valid_i         = 1'b1;
        do begin
            @(negedge clk);
            acc = bus.ast_ready_o;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 300);
        if (!acc) begin
            n_checks++;
            n_err++;
            $display("FAIL accept_timeout: beat 0x%0h not accepted in %0d cycles, required acceptance", d, n);
        end
        bus.ast_valid_i = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        bus.ast_valid_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input int dirv, input int dir_after, input int len,
                            input logic [DW-1:0] base, input bit rnd);
        logic [CW-1:0] ch;
        ch = CW'($urandom);
        for (int i = 0; i < len; i++) begin
            if (rnd && $urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
            dir = SW'((i == 0) ? dirv : (rnd ? int'($urandom_range(0, 3)) : dir_after));
            send_beat(base + DW'(i), (i == 0) || (rnd && $urandom_range(0, 7) == 0),
                      i == len - 1, EW'($urandom), ch);
        end
    endtask

    task automatic drain();
        int n = 0;
        ready_set = '1;
        rnd_ready = 1'b0;
        while ((mq[0].size() + mq[1].size() + mq[2].size()) != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        if (n >= 100) begin
            n_checks++;
            n_err++;
            $display("FAIL drain_timeout: outputs still occupied after %0d cycles, required empty", n);
        end
    endtask

    typedef struct {
        int            dirv;
        int            len;
        logic [DW-1:0] base;
        int            exp_dst;   // -1: packet dropped
        int            exp_drop;  // drop counter after the packet
    } vec_t;

    vec_t tbl [6];
    int   snap [TX];

    initial begin
        tbl[0] = '{2, 3, 64'hA0, 2, 0};
        tbl[1] = '{0, 1, 64'hB0, 0, 0};
        tbl[2] = '{3, 4, 64'hC0, -1, 1};
        tbl[3] = '{1, 2, 64'hD0, 1, 1};
        tbl[4] = '{3, 1, 64'hE0, -1, 2};
        tbl[5] = '{0, 5, 64'hF0, 0, 2};
        for (int d = 0; d < TX; d++) rcv_beats[d] = 0;

        srst = 1'b1;
        dir  = '0;
        bus.ast_valid_i = 1'b0;
        bus.ast_startofpacket_i = 1'b0;
        bus.ast_endofpacket_i = 1'b0;
        bus.ast_data_i = '0;
        bus.ast_empty_i = '0;
        bus.ast_channel_i = '0;
        repeat (3) @(posedge clk);
        #1;
        srst = 1'b0;
        @(negedge clk);
        check("reset_valid", 64'(bus.ast_valid_o), 64'(0));
        check("reset_drop", 64'(drop_cnt), 64'(0));
        @(posedge clk);
        #1;

        // Packet table: routing and dropping
        for (int t = 0; t < 6; t++) begin
            for (int d = 0; d < TX; d++) snap[d] = rcv_beats[d];
            send_pkt(tbl[t].dirv, tbl[t].dirv, tbl[t].len, tbl[t].base, 1'b0);
            drain();
            for (int d = 0; d < TX; d++)
                check($sformatf("tbl%0d_beats[%0d]", t, d), 64'(rcv_beats[d] - snap[d]),
                      64'((d == tbl[t].exp_dst) ? tbl[t].len : 0));
            check($sformatf("tbl%0d_drop", t), 64'(drop_cnt), 64'(tbl[t].exp_drop));
        end

        // Direction change after SOP is ignored until the next packet
        for (int d = 0; d < TX; d++) snap[d] = rcv_beats[d];
        send_pkt(2, 1, 4, 64'h110, 1'b0);
        drain();
        check("dirsw_out2", 64'(rcv_beats[2] - snap[2]), 64'(4));
        check("dirsw_out1", 64'(rcv_beats[1] - snap[1]), 64'(0));
        send_pkt(1, 1, 2, 64'h120, 1'b0);
        drain();
        check("dirsw_next_out1", 64'(rcv_beats[1] - snap[1]), 64'(2));

        // Back-pressure on output 1 while output 0 holds a beat
        for (int d = 0; d < TX; d++) snap[d] = rcv_beats[d];
        ready_set = 3'b110;
        send_pkt(0, 0, 1, 64'h200, 1'b0);
        begin
            int stall = 0;
            fork
                send_pkt(1, 1, 6, 64'h300, 1'b0);
                begin
                    repeat (2) @(posedge clk);
                    #1;
                    ready_set[1] = 1'b0;
                    repeat (5) begin
                        @(negedge clk);
                        if (bus.ast_valid_i && !bus.ast_ready_o) stall++;
                        @(posedge clk);
                        #1;
                    end
                    ready_set[1] = 1'b1;
                end
            join
            check("bp_stalled", 64'(stall > 0), 64'(1));
        end
        @(negedge clk);
        check("bp_out0_held_valid", 64'(bus.ast_valid_o[0]), 64'(1));
        check("bp_out0_held_data", bus.ast_data_o[0], 64'h200);
        @(posedge clk);
        #1;
        drain();
        check("bp_out1_beats", 64'(rcv_beats[1] - snap[1]), 64'(6));
        check("bp_out0_beats", 64'(rcv_beats[0] - snap[0]), 64'(1));

        // Stray beat in IDLE is swallowed
        dir = SW'(1);
        send_beat(64'h5A5A, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("stray_no_valid", 64'(bus.ast_valid_o), 64'(0));
        check("stray_drop", 64'(drop_cnt), 64'(2));
        @(posedge clk);
        #1;

        // Reset in the middle of a packet to output 2
        dir = SW'(2);
        send_beat(64'h400, 1'b1, 1'b0, '0, 8'h33);
        bus.ast_data_i = 64'h401;
        bus.ast_startofpacket_i = 1'b0;
        bus.ast_valid_i = 1'b1;
        srst = 1'b1;
        @(posedge clk);
        #1;
        srst = 1'b0;
        bus.ast_valid_i = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", 64'(bus.ast_valid_o), 64'(0));
        check("rst_mid_drop", 64'(drop_cnt), 64'(0));
        @(posedge clk);
        #1;
        for (int d = 0; d < TX; d++) snap[d] = rcv_beats[d];
        send_pkt(0, 0, 3, 64'h500, 1'b0);
        drain();
        check("rst_after_out0", 64'(rcv_beats[0] - snap[0]), 64'(3));

        // Randomised traffic against the model
        rnd_ready = 1'b1;
        for (int p = 0; p < 60; p++) begin
            if ($urandom_range(0, 5) == 0) begin
                dir = SW'($urandom);
                send_beat(DW'($urandom), 1'b0, 1'($urandom), '0, '0);
            end
            send_pkt($urandom_range(0, 3), 0, $urandom_range(1, 5), DW'({$urandom, $urandom}), 1'b1);
            rnd_ready = 1'b1;
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
